// File: rtl/chan_select_reg.sv
// Registered N-to-1 channel selector, fixed-priority or round-robin.
// Optional grant counter port enabled by defining CHSEL_STATS_EN.
module chan_select_reg #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 2,
  parameter int MODE     = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  input  logic                      out_ready
`ifdef CHSEL_STATS_EN
  ,
  output logic [15:0]               grant_cnt
`endif
);

  logic                      load;
  logic                      win_any;
  logic                      fire;
  logic [CW-1:0]             win_idx;
  logic [CW-1:0]             ptr;
  logic [CW-1:0]             ptr_nxt;
  logic [WIDTH-1:0]          win_data;
  logic [CHANNELS-1:0]       vsh;
  logic [CHANNELS*WIDTH-1:0] dsh;
  int                        j;

  assign load = !out_valid || out_ready;
  assign fire = win_any && load && rst_n;

  // search requests starting at 0 (fixed) or at ptr (round-robin)
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    vsh     = '0;
    j       = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      j   = (MODE == 1) ? ((int'(ptr) + k) % CHANNELS) : k;
      vsh = in_valid >> j;
      if (!win_any && vsh[0]) begin
        win_any = 1'b1;
        win_idx = CW'(j);
      end
    end
  end

  // winner's word and the rotated pointer that follows it
  always_comb begin
    dsh      = in_data >> (int'(win_idx) * WIDTH);
    win_data = dsh[WIDTH-1:0];
    if (int'(win_idx) == CHANNELS - 1)
      ptr_nxt = '0;
    else
      ptr_nxt = win_idx + 1'b1;
  end

  // one-hot accept to the winner, only when the register can load
  always_comb begin
    in_ready = '0;
    if (fire)
      in_ready[win_idx] = 1'b1;
  end

  // output register and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_chan  <= win_idx;
      ptr       <= ptr_nxt;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CHSEL_STATS_EN
  // count accepted words, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grant_cnt <= '0;
    else if (fire)
      grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_chan_select_reg.sv
// Bench for chan_select_reg: three configurations share one stimulus.
// Random traffic against a behavioural model plus directed cases.
module tb_chan_select_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  iv = '0;
  logic [19:0] id = '0;
  logic        ordy = 1'b0;

  logic [1:0]  r0;
  logic [3:0]  r1, r2;
  logic        v0, v1, v2;
  logic [4:0]  d0, d1, d2;
  logic        c0;
  logic [1:0]  c1, c2;
`ifdef CHSEL_STATS_EN
  logic [15:0] g0, g1, g2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chan_select_reg #(.WIDTH(5), .CHANNELS(2), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1:0]), .in_data(id[9:0]),
    .in_ready(r0), .out_valid(v0), .out_data(d0), .out_chan(c0),
    .out_ready(ordy)
`ifdef CHSEL_STATS_EN
    , .grant_cnt(g0)
`endif
  );

  chan_select_reg #(.WIDTH(5), .CHANNELS(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(id),
    .in_ready(r1), .out_valid(v1), .out_data(d1), .out_chan(c1),
    .out_ready(ordy)
`ifdef CHSEL_STATS_EN
    , .grant_cnt(g1)
`endif
  );

  chan_select_reg #(.WIDTH(5), .CHANNELS(4), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_data(id),
    .in_ready(r2), .out_valid(v2), .out_data(d2), .out_chan(c2),
    .out_ready(ordy)
`ifdef CHSEL_STATS_EN
    , .grant_cnt(g2)
`endif
  );

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  // model: channel count and mode per instance
  int mch[3]  = '{2, 4, 4};
  int mmod[3] = '{0, 1, 0};
  int mv[3], md[3], mc[3], mp[3], mcnt[3];

  function automatic int pick(int ch, int mode, int p, logic [3:0] v);
    for (int k = 0; k < ch; k++) begin
      int q = mode ? (p + k) % ch : k;
      if (v[q]) return q;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] = 0; md[i] = 0; mc[i] = 0; mp[i] = 0; mcnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int w;
        bit ld;
        w  = pick(mch[i], mmod[i], mp[i], iv);
        ld = (mv[i] == 0) || ordy;
        if (ld && w >= 0) begin
          mv[i]   = 1;
          md[i]   = int'((id >> (w * 5)) & 20'h1f);
          mc[i]   = w;
          mp[i]   = (w + 1) % mch[i];
          mcnt[i] = (mcnt[i] + 1) & 16'hffff;
        end else if (ld) begin
          mv[i] = 0;
        end
      end
    end
  end

  // compare every DUT against the model mid-cycle
  always @(negedge clk) begin
    int av[3], ad[3], ac[3], ar[3];
    av = '{int'(v0), int'(v1), int'(v2)};
    ad = '{int'(d0), int'(d1), int'(d2)};
    ac = '{int'(c0), int'(c1), int'(c2)};
    ar = '{int'(r0), int'(r1), int'(r2)};
    for (int i = 0; i < 3; i++) begin
      int w, er;
      bit ld;
      w  = pick(mch[i], mmod[i], mp[i], iv);
      ld = (mv[i] == 0) || ordy;
      er = (rst_n && ld && w >= 0) ? (1 << w) : 0;
      chk($sformatf("u%0d_valid", i), av[i], mv[i]);
      chk($sformatf("u%0d_data", i), ad[i], md[i]);
      chk($sformatf("u%0d_chan", i), ac[i], mc[i]);
      chk($sformatf("u%0d_ready", i), ar[i], er);
    end
`ifdef CHSEL_STATS_EN
    chk("u0_cnt", int'(g0), mcnt[0]);
    chk("u1_cnt", int'(g1), mcnt[1]);
    chk("u2_cnt", int'(g2), mcnt[2]);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv = '0;
    ordy = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_all[5] = '{0, 1, 2, 3, 0};
    int rr_two[4] = '{0, 3, 0, 3};

    do_reset();
    chk("reset_valid", int'(v0), 0);
    chk("reset_ready", int'(r1), 0);

    // single channel on the 2-channel build
    iv = 4'b0001;
    id = 20'h0001b;
    ordy = 1'b1;
    step();
    chk("single_valid", int'(v0), 1);
    chk("single_data", int'(d0), 27);
    chk("single_chan", int'(c0), 0);

    // reset while a word is held
    iv = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", int'(v0), 0);
    chk("rst_async_data", int'(d0), 0);
    chk("rst_async_chan", int'(c0), 0);
    chk("rst_async_ready", int'(r0), 0);
    step();
    rst_n = 1'b1;

    // backpressure on the 2-channel build
    iv = 4'b0001;
    id = 20'h00009;
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    iv = 4'b0011;
    id = 20'h00294;
    #1;
    chk("bp_ready", int'(r0), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_data", int'(d0), 9);
      chk("bp_hold_valid", int'(v0), 1);
    end
    ordy = 1'b1;
    #1;
    chk("bp_release_ready", int'(r0), 1);
    step();
    chk("bp_next_valid", int'(v0), 1);
    chk("bp_next_data", int'(d0), 20);

    // fixed priority, 4 channels
    do_reset();
    iv = 4'b1010;
    ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fixed_chan", int'(c2), 1);
    end

    // round-robin, all requesting
    do_reset();
    iv = 4'b1111;
    ordy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_all_chan", int'(c1), rr_all[k]);
    end

    // round-robin, two requesters
    do_reset();
    iv = 4'b1001;
    ordy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_two_chan", int'(c1), rr_two[k]);
    end

    // random traffic with occasional async resets
    do_reset();
    for (int k = 0; k < 800; k++) begin
      iv = 4'($urandom);
      id = 20'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end

`ifdef CHSEL_STATS_EN
    do_reset();
    iv = 4'b0001;
    id = 20'h00003;
    ordy = 1'b1;
    for (int k = 0; k < 65537; k++)
      step();
    iv = '0;
    #1;
    chk("stats_wrap_u0", int'(g0), 1);
    chk("stats_wrap_u1", int'(g1), 1);
`endif

    iv = '0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_select_reg.md
CHAN_SELECT_REG -- requirements
Module: chan_select_reg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- WIDTH, 5, data bits per channel.
- CHANNELS, 2, number of input channels (2..16).
- MODE, 0, arbitration mode (0 = fixed priority, 1 = round-robin).
REQ-002 CW SHALL denote max(1, clog2(CHANNELS)).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, CHANNELS, per-channel request.
- in_data, in, CHANNELS*WIDTH, channel i at bits [i*WIDTH +: WIDTH].
- in_ready, out, CHANNELS, per-channel accept, combinational.
- out_valid, out, 1, output register holds a word.
- out_data, out, WIDTH, registered selected word.
- out_chan, out, CW, registered index of the source channel.
- out_ready, in, 1, downstream accept.
- grant_cnt, out, 16, accepted-word counter (only with CHSEL_STATS_EN).

Function
REQ-004 The block SHALL hold one output register stage (out_valid, out_data, out_chan).
REQ-005 The block SHALL compute load = !out_valid || out_ready.
REQ-006 At most one in_ready bit SHALL be high per cycle.
- That bit SHALL be the arbitration winner among the in_valid bits.
- It SHALL be high only when load is 1.
REQ-007 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i] at a rising edge.
- On that edge, out_data SHALL load in_data[i], out_chan SHALL load i, and out_valid SHALL set to 1.
- Latency SHALL be 1 cycle from accept to out_valid.
REQ-008 When load is 1 and no in_valid bit is high, out_valid SHALL clear on the edge if out_ready was 1.
- out_data and out_chan SHALL then hold their last values.
REQ-009 While out_valid && !out_ready, out_data, out_chan and out_valid SHALL remain stable.
- All in_ready bits SHALL be 0 during this condition.
REQ-010 When out_valid && out_ready and a new transfer occurs on the same edge, the register SHALL reload.
- This gives full throughput: one word per cycle, no bubble.
REQ-011 MODE=0: the lowest-index asserted in_valid SHALL win.
REQ-012 MODE=1: a pointer ptr (CW bits) SHALL select the winner.
- The winner SHALL be the first asserted in_valid at index ptr, ptr+1, ... with wrap-around modulo CHANNELS.
- After a transfer on channel i, ptr SHALL become (i+1) mod CHANNELS, with wrap from CHANNELS-1 to 0.
- ptr SHALL be unchanged when no transfer occurs.
REQ-013 A requester SHALL NOT be required to hold in_valid; a dropped request SHALL simply not be granted.
REQ-014 The block SHALL tolerate in_data changing while in_ready is low, with no effect on outputs.

Reset
REQ-015 While rst_n is 0, the block SHALL immediately force its state to reset values, independent of clk:
- out_valid = 0, out_data = 0, out_chan = 0, ptr = 0, grant_cnt = 0.
REQ-016 A word held in the output register when reset asserts SHALL be discarded.
REQ-017 in_ready SHALL be all-zero while rst_n is 0.
REQ-018 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Configuration
REQ-019 With macro CHSEL_STATS_EN defined, port grant_cnt SHALL exist.
- grant_cnt SHALL increment by 1 on every transfer.
- It SHALL wrap from 16'hFFFF to 0.
REQ-020 Without CHSEL_STATS_EN, grant_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 at once, in_ready=0.
- Single channel (WIDTH=5, CHANNELS=2): in_valid=2'b01, in_data[4:0]=5'b11011, out_ready=1 -> next cycle out_valid=1, out_data=5'b11011, out_chan=0.
- Backpressure: out_valid=1, out_ready=0, in_valid=2'b11 -> in_ready=2'b00; out_data stable for 3 cycles; out_ready=1 -> next word loads with no bubble.
- Fixed priority (MODE=0, CHANNELS=4): in_valid=4'b1010 held, out_ready=1 -> out_chan=1 every cycle.
- Round-robin (MODE=1, CHANNELS=4): in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0; with in_valid=4'b1001 -> 0,3,0,3.
- CHSEL_STATS_EN: 65537 transfers -> grant_cnt=1 after wrap.
